// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage: reset PC, bus width,
//   fetch FSM state encodings and the redirect priority order.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam int          BUS_AW   = 32;

    // Fetch FSM: ISSUE drives the address phase, WAIT waits for read data,
    // HOLD keeps a returned instruction while the pipeline is stalled.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetchState_e;

    // Redirect sources.
    typedef enum logic [1:0] {
        REDIR_NONE          = 2'd0,
        REDIR_EXCEPTION     = 2'd1,
        REDIR_MISPREDICT    = 2'd2,
        REDIR_JUMP_CONFLICT = 2'd3
    } redirSrc_e;

    // Redirect priority: exception/eret > mispredict > jump conflict.
    function automatic redirSrc_e redirSelect(input logic exception,
                                              input logic mispredict,
                                              input logic jumpConflict);
        if (exception)    return REDIR_EXCEPTION;
        if (mispredict)   return REDIR_MISPREDICT;
        if (jumpConflict) return REDIR_JUMP_CONFLICT;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     flush_exceptionM / pc_exceptionM         exception or eret redirect
//     flush_pred_failedM / pc_correctM         mispredict redirect
//     flush_jump_conflictE / pc_jumpE          jump-conflict redirect
//     pred_takeD / pc_branchD                  predicted-taken branch in D
//     jumpD / pc_jumpD                         jump in D
//     pcPlus4                                  sequential successor of pcF
//     redir                                    any redirect is active
//     pcNext                                   value pcF loads on redirect/advance
// -----------------------------------------------------------------------------
module pc_next_sel
    import fetch_unit_pkg::*;
(
    input  logic        flush_exceptionM,
    input  logic [31:0] pc_exceptionM,
    input  logic        flush_pred_failedM,
    input  logic [31:0] pc_correctM,
    input  logic        flush_jump_conflictE,
    input  logic [31:0] pc_jumpE,
    input  logic        pred_takeD,
    input  logic [31:0] pc_branchD,
    input  logic        jumpD,
    input  logic [31:0] pc_jumpD,
    input  logic [31:0] pcPlus4,
    output logic        redir,
    output logic [31:0] pcNext
);

    redirSrc_e redirSrc;

    assign redirSrc = redirSelect(flush_exceptionM, flush_pred_failedM,
                                  flush_jump_conflictE);
    assign redir    = (redirSrc != REDIR_NONE);

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        pcNext = pcPlus4;
        case (redirSrc)
            REDIR_EXCEPTION:     pcNext = pc_exceptionM;
            REDIR_MISPREDICT:    pcNext = pc_correctM;
            REDIR_JUMP_CONFLICT: pcNext = pc_jumpE;
            default: begin
                // D-stage targets take effect as the delay slot leaves F.
                if (jumpD)           pcNext = pc_jumpD;
                else if (pred_takeD) pcNext = pc_branchD;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
//   an SRAM-like instruction bus (req / addr_ok / data_ok), holds a returned
//   instruction across stalls and discards stale responses after a redirect.
//   Ports:
//     clk, rst                       clock; asynchronous active-low reset
//     stallF                         hazard unit holds F
//     flush_* / pc_*                 redirect requests and targets (M/E stage)
//     pred_takeD, pc_branchD         predicted-taken branch in D
//     jumpD, pc_jumpD                jump in D
//     inst_req, inst_addr            bus request
//     inst_addr_ok, inst_data_ok,
//     inst_rdata                     bus responses
//     pcF, pc_plus4F                 fetch PC and its successor
//     instrF, inst_validF            fetched instruction (0 when not valid)
//     pc_errorF                      pcF is not word aligned
//     fetch_stallF                   F is not ready; stall request
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
    parameter int          BUS_AW   = fetch_unit_pkg::BUS_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              flush_exceptionM,
    input  logic [31:0]       pc_exceptionM,
    input  logic              flush_pred_failedM,
    input  logic [31:0]       pc_correctM,
    input  logic              flush_jump_conflictE,
    input  logic [31:0]       pc_jumpE,
    input  logic              pred_takeD,
    input  logic [31:0]       pc_branchD,
    input  logic              jumpD,
    input  logic [31:0]       pc_jumpD,
    output logic              inst_req,
    output logic [BUS_AW-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic [31:0]       pcF,
    output logic [31:0]       pc_plus4F,
    output logic [31:0]       instrF,
    output logic              inst_validF,
    output logic              pc_errorF,
    output logic              fetch_stallF
);

    fetchState_e stateQ, stateD;
    logic        discardQ, discardD;   // one stale response is still in flight
    logic [31:0] bufferQ, bufferD;     // instruction held across a stall
    logic        redir;
    logic        adv;
    logic [31:0] pcNext;

    assign pc_plus4F = pcF + 32'd4;    // wraps modulo 2^32
    assign pc_errorF = (pcF[1:0] != 2'b00);
    assign inst_addr = pcF[BUS_AW-1:0];

    pc_next_sel u_pc_next_sel (
        .flush_exceptionM     (flush_exceptionM),
        .pc_exceptionM        (pc_exceptionM),
        .flush_pred_failedM   (flush_pred_failedM),
        .pc_correctM          (pc_correctM),
        .flush_jump_conflictE (flush_jump_conflictE),
        .pc_jumpE             (pc_jumpE),
        .pred_takeD           (pred_takeD),
        .pc_branchD           (pc_branchD),
        .jumpD                (jumpD),
        .pc_jumpD             (pc_jumpD),
        .pcPlus4              (pc_plus4F),
        .redir                (redir),
        .pcNext               (pcNext)
    );

    assign adv          = inst_validF & ~stallF & ~redir;
    assign fetch_stallF = ~inst_validF & ~redir;

    always_comb begin
        stateD      = stateQ;
        discardD    = discardQ;
        bufferD     = bufferQ;
        inst_req    = 1'b0;
        inst_validF = 1'b0;
        instrF      = 32'd0;
        case (stateQ)
            ISSUE: begin
                // A redirect suppresses the request, so addr_ok can never
                // coincide with a PC change in this state.
                inst_req = rst & ~pc_errorF & ~redir;
                if (pc_errorF) begin
                    // Misaligned PC: deliver a zero word so the address error
                    // travels down the pipe with this PC.
                    inst_validF = 1'b1;
                end else if (inst_req && inst_addr_ok) begin
                    stateD = WAIT;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (discardQ) begin
                        discardD = 1'b0;
                        stateD   = ISSUE;
                    end else begin
                        inst_validF = 1'b1;
                        instrF      = inst_rdata;
                        if (stallF && !redir) begin
                            stateD  = HOLD;
                            bufferD = inst_rdata;
                        end else begin
                            stateD = ISSUE;
                        end
                    end
                end else if (redir) begin
                    // The response for the old PC is still coming; drop it.
                    discardD = 1'b1;
                end
            end
            HOLD: begin
                inst_validF = 1'b1;
                instrF      = bufferQ;
                if (!stallF || redir) stateD = ISSUE;
            end
            default: stateD = ISSUE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= ISSUE;
            discardQ <= 1'b0;
            // NOTE: the buffer is only read in HOLD, but it is cleared on
            // reset anyway so instrF never shows X after reset.
            bufferQ  <= 32'd0;
            pcF      <= RESET_PC;
        end else begin
            stateQ   <= stateD;
            discardQ <= discardD;
            bufferQ  <= bufferD;
            if (redir || adv) pcF <= pcNext;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallF = 1'b0;
    logic        flush_exceptionM = 1'b0;
    logic [31:0] pc_exceptionM = '0;
    logic        flush_pred_failedM = 1'b0;
    logic [31:0] pc_correctM = '0;
    logic        flush_jump_conflictE = 1'b0;
    logic [31:0] pc_jumpE = '0;
    logic        pred_takeD = 1'b0;
    logic [31:0] pc_branchD = '0;
    logic        jumpD = 1'b0;
    logic [31:0] pc_jumpD = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic [31:0] pcF, pc_plus4F, instrF;
    logic        inst_validF, pc_errorF, fetch_stallF;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .BUS_AW(32)) dut (
        .clk(clk), .rst(rst), .stallF(stallF),
        .flush_exceptionM(flush_exceptionM), .pc_exceptionM(pc_exceptionM),
        .flush_pred_failedM(flush_pred_failedM), .pc_correctM(pc_correctM),
        .flush_jump_conflictE(flush_jump_conflictE), .pc_jumpE(pc_jumpE),
        .pred_takeD(pred_takeD), .pc_branchD(pc_branchD),
        .jumpD(jumpD), .pc_jumpD(pc_jumpD),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .pcF(pcF), .pc_plus4F(pc_plus4F), .instrF(instrF),
        .inst_validF(inst_validF), .pc_errorF(pc_errorF), .fetch_stallF(fetch_stallF)
    );

    typedef struct packed {
        logic        stall;
        logic        fExc;
        logic [31:0] pcExc;
        logic        fPred;
        logic [31:0] pcCorr;
        logic        fJc;
        logic [31:0] pcJe;
        logic        pred;
        logic [31:0] pcBr;
        logic        jump;
        logic [31:0] pcJd;
    } ctl_t;

    int   checks = 0;
    int   errors = 0;
    ctl_t ctl = '0;

    // Bus slave: one outstanding read, returned after pendDelay extra cycles.
    bit          pending = 0;
    logic [31:0] pendAddr = '0;
    int          pendDelay = 0;
    bit          busRandom = 0;
    int          fixedDelay = 0;
    bit          addrOkFixed = 0;
    bit          overrideOn = 0;
    logic [31:0] overrideVal = '0;

    // Reference model state.
    logic [31:0] modelPc = RST_PC;
    bit          prevHeld = 0;
    logic [31:0] prevInstr = '0;
    int          sinceValid = 0;

    // Memory contents: a bijection of the address, so a word fetched for the
    // wrong PC never matches the expected one.
    function automatic logic [31:0] dataFor(input logic [31:0] a);
        if (overrideOn) return overrideVal;
        return a * 32'h9e37_79b1 + 32'h0000_1234;
    endfunction

    function automatic logic [31:0] randPc(input bit allowMisaligned);
        logic [31:0] a;
        a = 32'hbfc0_0000 | ($urandom & 32'h0000_0ffc);
        if (allowMisaligned && $urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Checks the cycle's outputs against the architectural rules and advances
    // the model PC.
    task automatic modelStep();
        logic        redir;
        logic        misal;
        logic [31:0] want;
        redir = ctl.fExc | ctl.fPred | ctl.fJc;
        misal = (modelPc[1:0] != 2'b00);
        checks++;
        if (pcF !== modelPc) begin
            errors++; $display("FAIL model_pcF got %h want %h at %0t", pcF, modelPc, $time);
        end
        checks++;
        if (pc_plus4F !== modelPc + 32'd4) begin
            errors++; $display("FAIL model_pc_plus4F got %h want %h", pc_plus4F, modelPc + 32'd4);
        end
        checks++;
        if (pc_errorF !== misal) begin
            errors++; $display("FAIL model_pc_errorF got %b want %b", pc_errorF, misal);
        end
        checks++;
        if (inst_addr !== modelPc) begin
            errors++; $display("FAIL model_inst_addr got %h want %h", inst_addr, modelPc);
        end
        checks++;
        if (fetch_stallF !== (!inst_validF && !redir)) begin
            errors++; $display("FAIL model_fetch_stallF got %b want %b", fetch_stallF, !inst_validF && !redir);
        end
        if (redir || misal) begin
            checks++;
            if (inst_req !== 1'b0) begin
                errors++; $display("FAIL model_req_gated got %b want 0", inst_req);
            end
        end
        want = (!inst_validF || misal) ? 32'd0 : dataFor(modelPc);
        checks++;
        if (instrF !== want) begin
            errors++; $display("FAIL model_instrF got %h want %h at %0t", instrF, want, $time);
        end
        if (prevHeld) begin
            checks++;
            if (inst_validF !== 1'b1 || instrF !== prevInstr) begin
                errors++; $display("FAIL model_hold got v=%b %h want v=1 %h", inst_validF, instrF, prevInstr);
            end
        end
        if (inst_validF || redir) sinceValid = 0; else sinceValid++;
        checks++;
        if (sinceValid > 200) begin
            errors++; $display("FAIL model_progress got %0d idle cycles want <= 200", sinceValid);
            sinceValid = 0;
        end
        prevHeld  = inst_validF && ctl.stall && !redir;
        prevInstr = instrF;
        if (ctl.fExc)                          modelPc = ctl.pcExc;
        else if (ctl.fPred)                    modelPc = ctl.pcCorr;
        else if (ctl.fJc)                      modelPc = ctl.pcJe;
        else if (inst_validF && !ctl.stall) begin
            if (ctl.jump)      modelPc = ctl.pcJd;
            else if (ctl.pred) modelPc = ctl.pcBr;
            else               modelPc = modelPc + 32'd4;
        end
    endtask

    // One clock: apply ctl and bus responses after the edge, check mid-cycle.
    task automatic cycle();
        @(posedge clk); #1;
        stallF = ctl.stall;
        flush_exceptionM = ctl.fExc;   pc_exceptionM = ctl.pcExc;
        flush_pred_failedM = ctl.fPred; pc_correctM = ctl.pcCorr;
        flush_jump_conflictE = ctl.fJc; pc_jumpE = ctl.pcJe;
        pred_takeD = ctl.pred;         pc_branchD = ctl.pcBr;
        jumpD = ctl.jump;              pc_jumpD = ctl.pcJd;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        if (pending) begin
            if (pendDelay == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = dataFor(pendAddr);
            end else begin
                pendDelay--;
            end
        end
        inst_addr_ok = busRandom ? ($urandom_range(0, 9) < 7) : addrOkFixed;
        #3;
        modelStep();
        if (inst_data_ok) pending = 0;
        if (inst_req && inst_addr_ok) begin
            checks++;
            if (pending) begin
                errors++; $display("FAIL bus_single_outstanding got 2 outstanding want 1");
            end
            pending   = 1;
            pendAddr  = inst_addr;
            pendDelay = busRandom ? $urandom_range(0, 3) : fixedDelay;
        end
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst = 1'b0;
        ctl = '0;
        stallF = 0; flush_exceptionM = 0; flush_pred_failedM = 0; flush_jump_conflictE = 0;
        pred_takeD = 0; jumpD = 0; inst_addr_ok = 0; inst_data_ok = 0;
        pending = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        modelPc = RST_PC; prevHeld = 0; sinceValid = 0;
        overrideOn = 0; busRandom = 0; fixedDelay = 0; addrOkFixed = 1;
    endtask

    task automatic test_reset();
        @(posedge clk); #4;
        checks++;
        if (inst_req !== 1'b0 || pcF !== RST_PC || pc_plus4F !== RST_PC + 32'd4) begin
            errors++; $display("FAIL reset_values got req=%b pc=%h p4=%h want 0 %h %h", inst_req, pcF, pc_plus4F, RST_PC, RST_PC + 32'd4);
        end
        checks++;
        if (inst_validF !== 1'b0 || instrF !== 32'd0 || fetch_stallF !== 1'b1 || pc_errorF !== 1'b0) begin
            errors++; $display("FAIL reset_flags got v=%b i=%h s=%b e=%b want 0 0 1 0", inst_validF, instrF, fetch_stallF, pc_errorF);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        addrOkFixed = 0; fixedDelay = 5;
        ctl.fPred = 1; ctl.pcCorr = 32'hbfc0_0040;
        cycle();
        ctl = '0; addrOkFixed = 1;
        cycle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0040) begin
            errors++; $display("FAIL reset_redirect_req got %b %h want 1 bfc00040", inst_req, inst_addr);
        end
        cycle();
        // Asynchronous reset in the middle of an outstanding read.
        @(posedge clk); #1;
        rst = 1'b0; inst_addr_ok = 0; inst_data_ok = 0; pending = 0;
        #3;
        checks++;
        if (pcF !== RST_PC || inst_req !== 1'b0 || inst_validF !== 1'b0) begin
            errors++; $display("FAIL reset_async got pc=%h req=%b v=%b want %h 0 0", pcF, inst_req, inst_validF, RST_PC);
        end
        @(posedge clk); #1;
        rst = 1'b1; modelPc = RST_PC; prevHeld = 0; sinceValid = 0;
        cycle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RST_PC) begin
            errors++; $display("FAIL reset_abandon got %b %h want 1 %h", inst_req, inst_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] expPc;
        applyReset();
        for (int c = 0; c < 6; c++) begin
            cycle();
            expPc = RST_PC + 32'(4 * (c / 2));
            checks++;
            if (inst_validF !== ((c % 2) == 1)) begin
                errors++; $display("FAIL seq_valid c%0d got %b want %b", c, inst_validF, (c % 2) == 1);
            end
            checks++;
            if (pcF !== expPc) begin
                errors++; $display("FAIL seq_pc c%0d got %h want %h", c, pcF, expPc);
            end
            if ((c % 2) == 0) begin
                checks++;
                if (inst_req !== 1'b1 || inst_addr !== expPc) begin
                    errors++; $display("FAIL seq_req c%0d got %b %h want 1 %h", c, inst_req, inst_addr, expPc);
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        applyReset();
        cycle();
        ctl.stall = 1;
        overrideOn = 1; overrideVal = 32'h2402_0001;
        cycle();
        checks++;
        if (inst_validF !== 1'b1 || instrF !== 32'h2402_0001) begin
            errors++; $display("FAIL hold_capture got %b %h want 1 24020001", inst_validF, instrF);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (inst_validF !== 1'b1 || instrF !== 32'h2402_0001 || inst_req !== 1'b0 || pcF !== RST_PC) begin
                errors++; $display("FAIL hold_cycle%0d got v=%b i=%h req=%b pc=%h want 1 24020001 0 %h", i, inst_validF, instrF, inst_req, pcF, RST_PC);
            end
        end
        ctl.stall = 0;
        cycle();
        overrideOn = 0;
        cycle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RST_PC + 32'd4) begin
            errors++; $display("FAIL hold_release got %b %h want 1 %h", inst_req, inst_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_mispredict_discard();
        bit found;
        applyReset();
        fixedDelay = 2;
        cycle();
        ctl.fPred = 1; ctl.pcCorr = 32'hbfc0_0100;
        cycle();
        checks++;
        if (inst_req !== 1'b0 || fetch_stallF !== 1'b0) begin
            errors++; $display("FAIL mp_redirect got req=%b stall=%b want 0 0", inst_req, fetch_stallF);
        end
        ctl = '0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (inst_data_ok) begin
                found = 1;
                checks++;
                if (inst_validF !== 1'b0) begin
                    errors++; $display("FAIL mp_stale_dropped got %b want 0", inst_validF);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mp_stale_timeout got none want data_ok");
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (inst_req) begin
                found = 1;
                checks++;
                if (inst_addr !== 32'hbfc0_0100) begin
                    errors++; $display("FAIL mp_new_addr got %h want bfc00100", inst_addr);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mp_req_timeout got none want inst_req");
        end
    endtask

    task automatic test_redirect_priority();
        applyReset();
        ctl.fExc = 1; ctl.pcExc = 32'hbfc0_0380;
        ctl.fJc  = 1; ctl.pcJe  = 32'hbfc0_0500;
        cycle();
        ctl = '0;
        cycle();
        checks++;
        if (pcF !== 32'hbfc0_0380) begin
            errors++; $display("FAIL prio_exc_over_jc got %h want bfc00380", pcF);
        end
        // Data returns in the same cycle as a mispredict + jump conflict.
        ctl.fPred = 1; ctl.pcCorr = 32'hbfc0_0600;
        ctl.fJc   = 1; ctl.pcJe   = 32'hbfc0_0700;
        cycle();
        ctl = '0;
        cycle();
        checks++;
        if (pcF !== 32'hbfc0_0600) begin
            errors++; $display("FAIL prio_mp_over_jc got %h want bfc00600", pcF);
        end
    endtask

    task automatic test_jump_delay_slot();
        bit found;
        applyReset();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = inst_validF;
        end
        ctl.jump = 1; ctl.pcJd = 32'hbfc0_0200;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (inst_validF) begin
                found = 1;
                checks++;
                if (pcF !== RST_PC + 32'd4 || instrF !== dataFor(RST_PC + 32'd4)) begin
                    errors++; $display("FAIL jump_delay_slot got %h %h want %h %h", pcF, instrF, RST_PC + 32'd4, dataFor(RST_PC + 32'd4));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL jump_slot_timeout got none want inst_validF");
        end
        ctl = '0;
        cycle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0200) begin
            errors++; $display("FAIL jump_target got %b %h want 1 bfc00200", inst_req, inst_addr);
        end
    endtask

    task automatic test_misaligned_pc();
        applyReset();
        ctl.fExc = 1; ctl.pcExc = 32'hbfc0_0382;
        cycle();
        ctl = '0; ctl.stall = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (pc_errorF !== 1'b1 || inst_req !== 1'b0 || inst_validF !== 1'b1 || instrF !== 32'd0 || pcF !== 32'hbfc0_0382) begin
                errors++; $display("FAIL misal_%0d got e=%b req=%b v=%b i=%h pc=%h want 1 0 1 0 bfc00382", i, pc_errorF, inst_req, inst_validF, instrF, pcF);
            end
        end
        ctl = '0; ctl.fPred = 1; ctl.pcCorr = 32'hbfc0_0400;
        cycle();
        ctl = '0;
        cycle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0400 || pc_errorF !== 1'b0) begin
            errors++; $display("FAIL misal_resume got %b %h e=%b want 1 bfc00400 0", inst_req, inst_addr, pc_errorF);
        end
        cycle();
        checks++;
        if (inst_validF !== 1'b1 || instrF !== dataFor(32'hbfc0_0400)) begin
            errors++; $display("FAIL misal_fetch got %b %h want 1 %h", inst_validF, instrF, dataFor(32'hbfc0_0400));
        end
    endtask

    task automatic test_random();
        applyReset();
        busRandom = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                applyReset();
                busRandom = 1;
            end
            ctl.stall  = ($urandom_range(0, 9) < 3);
            ctl.fExc   = ($urandom_range(0, 99) < 3);
            ctl.pcExc  = randPc(1);
            ctl.fPred  = ($urandom_range(0, 99) < 4);
            ctl.pcCorr = randPc(0);
            ctl.fJc    = ($urandom_range(0, 99) < 4);
            ctl.pcJe   = randPc(0);
            ctl.jump   = ($urandom_range(0, 99) < 15);
            ctl.pcJd   = randPc(0);
            ctl.pred   = ($urandom_range(0, 99) < 15);
            ctl.pcBr   = randPc(0);
            cycle();
        end
        ctl = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_mispredict_discard();
        test_redirect_priority();
        test_jump_delay_slot();
        test_misaligned_pc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
